// File: rtl/product_accumulator.sv
// Streaming accumulator: sums len unsigned 64-bit products into an ACC_W-bit result.
// Define PRODUCT_ACC_SAT_EN to clamp the sum to all-ones on carry instead of wrapping.
module product_accumulator #(
    parameter int ACC_W = 64,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic [63:0]      product,
    input  logic             prod_valid,
    output logic             prod_ready,
    output logic [ACC_W-1:0] result,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             overflow,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        OUT
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic [ACC_W:0]   sum;
    logic             beat;

    // One spare bit on top captures the carry out of the accumulator
    assign sum  = {1'b0, acc} + {{(ACC_W - 63){1'b0}}, product};
    assign beat = (state == ACC) && prod_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        prod_ready = 1'b0;
        res_valid  = 1'b0;
        busy       = 1'b1;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nx = (len == '0) ? OUT : ACC;
                end
            end
            ACC: begin
                prod_ready = 1'b1;
                if (prod_valid && cnt == CNT_W'(1)) begin
                    state_nx = OUT;
                end
            end
            OUT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (state == IDLE && start) begin
            acc <= '0;
            cnt <= len;
            ovf <= 1'b0;
        end else if (beat) begin
            cnt <= cnt - 1'b1;
            ovf <= ovf | sum[ACC_W];
`ifdef PRODUCT_ACC_SAT_EN
            // Once clamped, stay pinned at all-ones for the rest of the run
            acc <= (sum[ACC_W] || ovf) ? '1 : sum[ACC_W-1:0];
`else
            acc <= sum[ACC_W-1:0];
`endif
        end
    end

    assign result   = acc;
    assign overflow = ovf;

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 Parameter ACC_W, default 64, accumulator and result width; legal range 64..128.
REQ-002 Parameter CNT_W, default 8, width of the beat-count input len.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request a new accumulation; sampled only in IDLE.
REQ-006 len  input  CNT_W  number of products to accumulate; sampled with start.
REQ-007 product  input  64  unsigned 64-bit product from the upstream 32x32 multiplier.
REQ-008 prod_valid  input  1  product is valid this cycle.
REQ-009 prod_ready  output  1  accumulator accepts product this cycle.
REQ-010 result  output  ACC_W  accumulated sum.
REQ-011 res_valid  output  1  result is final and held.
REQ-012 res_ready  input  1  downstream consumes result.
REQ-013 overflow  output  1  sticky flag: a carry out of ACC_W occurred during this run.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 FSM states SHALL be IDLE, ACC and OUT; IDLE is the reset state.
REQ-016 IDLE: prod_ready=0, res_valid=0; on start=1, clear acc to 0, clear overflow, load cnt=len, and go to OUT if len==0, else to ACC.
REQ-017 ACC: prod_ready=1; a beat is accepted when prod_valid&&prod_ready, which sets acc<=acc+zero_extend(product) and cnt<=cnt-1.
REQ-018 When the accepted beat has cnt==1, the next state SHALL be OUT; res_valid rises exactly 1 cycle after the last accepted beat, and result then includes that beat.
REQ-019 ACC with prod_valid=0: no state change, with no timeout.
REQ-020 OUT: res_valid=1, prod_ready=0; result and overflow SHALL stay stable until res_ready=1, then the FSM returns to IDLE.
REQ-021 start SHALL be ignored in ACC and OUT, including the cycle of the OUT handshake; a new run requires start in IDLE.
REQ-022 Arithmetic is unsigned ACC_W-bit; overflow is set on any carry out of bit ACC_W-1 and stays set until the next start or rst.
REQ-023 result SHALL equal acc in every state; after an OUT handshake it keeps the last sum until the next start.

Reset
REQ-024 rst=1 SHALL, at the next edge, force state IDLE, acc=0, cnt=0, overflow=0, result=0, res_valid=0, prod_ready=0 and busy=0.
REQ-025 rst SHALL take priority over start and over all handshakes, including mid-ACC and mid-OUT; a partial run is discarded and never reported.

Configuration
REQ-026 Macro PRODUCT_ACC_SAT_EN defined: on carry, acc SHALL clamp to all-ones and remain there for the rest of the run, with overflow=1.
REQ-027 Macro PRODUCT_ACC_SAT_EN undefined: acc SHALL wrap modulo 2^ACC_W, with overflow=1.

Verification
REQ-028 Single beat: len=1, product=1, res_ready=1 -> res_valid 1 cycle after accept, result=1, overflow=0.
REQ-029 Three beats: len=3; products 0x6, 0x0100000000000000, 0x00000000FFFFFFFF, with gaps where prod_valid=0 -> result=0x0100000100000005; exactly 3 accepts.
REQ-030 Overflow: len=2, both products 0xFFFFFFFE00000001 (ACC_W=64):
  - macro undefined -> result=0xFFFFFFFC00000002, overflow=1.
  - macro defined -> result=0xFFFFFFFFFFFFFFFF, overflow=1.
REQ-031 Zero length: start with len=0 -> no prod_ready pulse; res_valid in the next cycle; result=0.
REQ-032 Backpressure: in OUT, hold res_ready=0 for 5 cycles and pulse start -> result stable, res_valid=1, prod_ready=0, start ignored; res_ready=1 -> IDLE next cycle.
REQ-033 Reset mid-run: len=3, rst after 1 beat -> next cycle IDLE, all outputs 0; then len=1, product=7 -> result=7, overflow=0.
